// File: rtl/chk_insert_scheduler.sv
// Checksum-insertion sequencer: forwards data beats, closes blocks of up to BLOCK_BEATS
// beats (or earlier on inp_last), and inserts one tagged checksum beat per block.
module chk_insert_scheduler #(
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned KEEP_W      = 64,
  parameter int unsigned ID_W        = 6,
  parameter int unsigned BLOCK_BEATS = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] inp_data,
  input  logic [KEEP_W-1:0] inp_keep,
  input  logic [ID_W-1:0]   inp_id,
  input  logic              inp_last,
  input  logic              inp_valid,
  output logic              inp_ready,
  input  logic [DATA_W-1:0] chk_data,
  input  logic [ID_W-1:0]   chk_id,
  input  logic              chk_valid,
  output logic              chk_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  blk_count,
  output logic              err_id_mismatch
);

  localparam int unsigned     BEAT_W    = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_BEATS - 1);

  typedef enum logic {S_DATA, S_CHK} state_t;

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic              last_pend, last_pend_nxt;
  logic [ID_W-1:0]   blk_id, blk_id_nxt;
  logic              slot_free;
  logic              inp_fire;
  logic              chk_fire;

  // Ready depends only on state and output-slot occupancy; held low during reset.
  always_comb begin
    slot_free = !out_valid || out_ready;
    inp_ready = reset && (state == S_DATA) && slot_free;
    chk_ready = reset && (state == S_CHK) && slot_free;
    inp_fire  = inp_valid && inp_ready;
    chk_fire  = chk_valid && chk_ready;
  end

  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    last_pend_nxt = last_pend;
    blk_id_nxt    = blk_id;
    case (state)
      S_DATA: begin
        if (inp_fire) begin
          if (beat_cnt == '0) blk_id_nxt = inp_id;
          if (inp_last || (beat_cnt == LAST_BEAT)) begin
            beat_cnt_nxt  = '0;
            last_pend_nxt = inp_last;
            state_nxt     = S_CHK;
          end else begin
            beat_cnt_nxt = beat_cnt + BEAT_W'(1);
          end
        end
      end
      S_CHK: begin
        if (chk_fire) begin
          last_pend_nxt = 1'b0;
          state_nxt     = S_DATA;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_DATA;
      beat_cnt  <= '0;
      last_pend <= 1'b0;
      blk_id    <= '0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      last_pend <= last_pend_nxt;
      blk_id    <= blk_id_nxt;
    end
  end

  // Single-entry output register; a load may coincide with draining the previous beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (inp_fire) begin
      out_data  <= inp_data;
      out_keep  <= inp_keep;
      out_id    <= inp_id;
      out_last  <= 1'b0;
      out_valid <= 1'b1;
    end else if (chk_fire) begin
      out_data  <= chk_data;
      out_keep  <= {KEEP_W{1'b1}};
      out_id    <= blk_id;
      out_last  <= last_pend;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blk_count       <= '0;
      err_id_mismatch <= 1'b0;
    end else if (chk_fire) begin
      blk_count <= blk_count + CNT_W'(1);
      if (chk_id != blk_id) err_id_mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chk_insert_scheduler.sv
// Scoreboard bench for chk_insert_scheduler: directed blocks push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_chk_insert_scheduler;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = 64;
  localparam int unsigned ID_W   = 6;
  localparam int unsigned BB     = 4;
  localparam int unsigned CNT_W  = 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [ID_W-1:0]   id;
    logic              last;
  } beat_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] inp_data = '0;
  logic [KEEP_W-1:0] inp_keep = '0;
  logic [ID_W-1:0]   inp_id = '0;
  logic              inp_last = 1'b0;
  logic              inp_valid = 1'b0;
  logic              inp_ready;
  logic [DATA_W-1:0] chk_data;
  logic [ID_W-1:0]   chk_id = '0;
  logic              chk_valid = 1'b0;
  logic              chk_ready;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic [ID_W-1:0]   out_id;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CNT_W-1:0]  blk_count;
  logic              err_id_mismatch;

  chk_insert_scheduler #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .ID_W(ID_W), .BLOCK_BEATS(BB), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .inp_data(inp_data), .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
    .inp_valid(inp_valid), .inp_ready(inp_ready),
    .chk_data(chk_data), .chk_id(chk_id), .chk_valid(chk_valid), .chk_ready(chk_ready),
    .out_data(out_data), .out_keep(out_keep), .out_id(out_id), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .blk_count(blk_count), .err_id_mismatch(err_id_mismatch)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  beat_t exp_q[$];

  function automatic logic [DATA_W-1:0] datapat(int n);
    return {16{32'hDA7A_0000 + 32'(n)}};
  endfunction

  function automatic logic [DATA_W-1:0] chkpat(int n);
    return {16{32'hC5C5_0000 + 32'(n)}};
  endfunction

  task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Checksum engine model: always has the next checksum ready when chk_valid is raised.
  int  chk_seq = 0;
  logic chk_will = 1'b0;
  assign chk_data = chkpat(chk_seq);
  always @(negedge clock) chk_will = chk_valid && chk_ready;
  always @(posedge clock) if (chk_will) begin
    #1 chk_seq++;
  end

  // Monitor
  int pop_cnt = 0;
  int first_pop = 0;
  int last_pop = 0;
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got data %0h with an empty expected queue", out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_meta", DATA_W'({out_keep, out_id, out_last}), DATA_W'({e.keep, e.id, e.last}));
      end
      if (pop_cnt == 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
  end

  // Reference block model
  int          d_seq = 0;
  int          m_chk = 0;
  int unsigned m_beat = 0;
  logic [ID_W-1:0] m_blk_id = '0;

  task automatic send_beat(input logic [ID_W-1:0] id, input logic last);
    logic r;
    int   n;
    beat_t b;
    inp_valid = 1'b1;
    inp_data  = datapat(d_seq);
    inp_keep  = 64'hFFFF_0000_FFFF_0000 ^ 64'(d_seq);
    inp_id    = id;
    inp_last  = last;
    n = 0;
    do begin
      @(negedge clock);
      r = inp_ready;
      @(posedge clock);
      n++;
    end while (!r && n < 50);
    #1;
    inp_valid = 1'b0;
    if (!r) begin
      checks++;
      failures++;
      $display("FAIL inp_handshake_timeout: got no inp_ready expected one within 50 cycles");
      return;
    end
    b.data = datapat(d_seq); b.keep = 64'hFFFF_0000_FFFF_0000 ^ 64'(d_seq);
    b.id = id; b.last = 1'b0;
    exp_q.push_back(b);
    d_seq++;
    if (m_beat == 0) m_blk_id = id;
    if (last || m_beat == BB - 1) begin
      b.data = chkpat(m_chk); b.keep = '1; b.id = m_blk_id; b.last = last;
      exp_q.push_back(b);
      m_chk++;
      m_beat = 0;
    end else begin
      m_beat++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", DATA_W'(out_valid), '0);
    check("rst_inp_ready", DATA_W'(inp_ready), '0);
    check("rst_chk_ready", DATA_W'(chk_ready), '0);
    check("rst_blk_count", DATA_W'(blk_count), '0);
    check("rst_err", DATA_W'(err_id_mismatch), '0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Full blocks, back-to-back
    chk_valid = 1'b1;
    chk_id = 6'd5;
    pop_cnt = 0;
    for (int i = 0; i < 8; i++) send_beat(6'd5, 1'b0);
    wait_idle();
    check("full_blk_count", DATA_W'(blk_count), DATA_W'(2));
    check("full_pop_cnt", DATA_W'(pop_cnt), DATA_W'(10));
    check("full_consecutive", DATA_W'(last_pop - first_pop), DATA_W'(9));

    // Short block, then a new block with a new id
    chk_id = 6'd7;
    send_beat(6'd7, 1'b0);
    send_beat(6'd7, 1'b1);
    wait_idle();
    chk_id = 6'd8;
    send_beat(6'd8, 1'b1);
    wait_idle();
    check("short_blk_count", DATA_W'(blk_count), DATA_W'(4));

    // Backpressure mid-block
    chk_id = 6'd9;
    send_beat(6'd9, 1'b0);
    out_ready = 1'b0;
    fork
      send_beat(6'd9, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          check("bp_out_valid", DATA_W'(out_valid), DATA_W'(1));
          check("bp_out_data", out_data, datapat(d_seq - 1));
          check("bp_inp_ready", DATA_W'(inp_ready), '0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    send_beat(6'd9, 1'b0);
    send_beat(6'd9, 1'b0);
    wait_idle();
    check("bp_blk_count", DATA_W'(blk_count), DATA_W'(5));

    // Checksum starvation
    chk_valid = 1'b0;
    chk_id = 6'd10;
    for (int i = 0; i < 4; i++) send_beat(6'd10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("starve_inp_ready", DATA_W'(inp_ready), '0);
    end
    @(posedge clock);
    #1 chk_valid = 1'b1;
    @(negedge clock);
    check("starve_chk_ready", DATA_W'(chk_ready), DATA_W'(1));
    @(negedge clock);
    check("starve_chk_out", DATA_W'({out_valid, out_id}), DATA_W'({1'b1, 6'd10}));
    check("starve_inp_ready_back", DATA_W'(inp_ready), DATA_W'(1));
    wait_idle();

    // Id mismatch is sticky
    chk_id = 6'd4;
    send_beat(6'd3, 1'b1);
    wait_idle();
    check("mismatch_err", DATA_W'(err_id_mismatch), DATA_W'(1));
    chk_id = 6'd12;
    send_beat(6'd12, 1'b1);
    wait_idle();
    check("mismatch_sticky", DATA_W'(err_id_mismatch), DATA_W'(1));
    check("mismatch_blk_count", DATA_W'(blk_count), DATA_W'(8));

    // Reset mid-block
    chk_id = 6'd20;
    send_beat(6'd20, 1'b0);
    send_beat(6'd20, 1'b0);
    reset = 1'b0;
    #1;
    check("mrst_out_valid", DATA_W'(out_valid), '0);
    check("mrst_out_data", out_data, '0);
    check("mrst_blk_count", DATA_W'(blk_count), '0);
    check("mrst_err", DATA_W'(err_id_mismatch), '0);
    check("mrst_inp_ready", DATA_W'(inp_ready), '0);
    check("mrst_held_beats", DATA_W'(exp_q.size()), DATA_W'(1));
    exp_q.delete();
    m_beat = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_id = 6'd21;
    for (int i = 0; i < 4; i++) send_beat(6'd21, 1'b0);
    wait_idle();
    check("post_rst_blk_count", DATA_W'(blk_count), DATA_W'(1));
    check("post_rst_err", DATA_W'(err_id_mismatch), '0);
    check("final_queue_empty", DATA_W'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
